zvc_compressor_pipe: RTL and testbench



---
 rtl/zvc_compressor_pipe.sv | 140 ++++++++++++++
 tb/tb_zvc_compressor_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zvc_compressor_pipe.sv
// rtl/zvc_compressor_pipe.sv - 3-stage zero-value compressor for LIFM/MT lines with valid/ready flow control.
// Optional statistics counters (stat_lines, stat_zeros, stat_clr) are enabled by defining ZVC_STATS_EN.
module zvc_compressor_pipe #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 32,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int CNT_WIDTH     = $clog2(LINE_SIZE + 1)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          mask_mode,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_line,
  input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_comp,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
  output logic [LINE_SIZE-1:0]                          keep_mask,
  output logic [CNT_WIDTH-1:0]                          nz_count
`ifdef ZVC_STATS_EN
  ,
  input  logic                                          stat_clr,
  output logic [31:0]                                   stat_lines,
  output logic [31:0]                                   stat_zeros
`endif
);

  localparam int MT_WIDTH = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int LW = LINE_SIZE * WORD_WIDTH;
  localparam int MW = LINE_SIZE * MT_WIDTH;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic                 a_valid;
  logic                 a_mode;
  logic [LW-1:0]        a_lifm;
  logic [MW-1:0]        a_mt;
  logic [LINE_SIZE-1:0] a_mask;
  logic [CNT_WIDTH-1:0] a_pos [LINE_SIZE];
  logic [CNT_WIDTH-1:0] a_count;

  logic                 b_valid;
  logic [LW-1:0]        b_lifm;
  logic [MW-1:0]        b_mt;
  logic [LINE_SIZE-1:0] b_mask;
  logic [CNT_WIDTH-1:0] b_pos [LINE_SIZE];
  logic [CNT_WIDTH-1:0] b_count;

  logic [LW-1:0]        c_lifm_n;
  logic [MW-1:0]        c_mt_n;

  always_comb begin
    a_mask = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      a_mask[i] = a_mode ? (|a_mt[i*MT_WIDTH +: MT_WIDTH])
                         : (|a_lifm[i*WORD_WIDTH +: WORD_WIDTH]);
    end
  end

  // Exclusive prefix sum: pos[i] counts kept words strictly below index i.
  always_comb begin : prefix_sum
    logic [CNT_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      a_pos[i] = acc;
      acc      = acc + CNT_WIDTH'(a_mask[i]);
    end
    a_count = acc;
  end

  // pos[i] <= i, so only slots 0..i are candidates for word i; unmatched slots stay 0.
  always_comb begin
    c_lifm_n = '0;
    c_mt_n   = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      if (b_mask[i]) begin
        for (int j = 0; j <= i; j++) begin
          if (b_pos[i] == CNT_WIDTH'(j)) begin
            c_lifm_n[j*WORD_WIDTH +: WORD_WIDTH] = b_lifm[i*WORD_WIDTH +: WORD_WIDTH];
            c_mt_n[j*MT_WIDTH +: MT_WIDTH]       = b_mt[i*MT_WIDTH +: MT_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid   <= 1'b0;
      a_mode    <= 1'b0;
      a_lifm    <= '0;
      a_mt      <= '0;
      b_valid   <= 1'b0;
      b_lifm    <= '0;
      b_mt      <= '0;
      b_mask    <= '0;
      b_count   <= '0;
      for (int i = 0; i < LINE_SIZE; i++) b_pos[i] <= '0;
      out_valid <= 1'b0;
      lifm_comp <= '0;
      mt_comp   <= '0;
      keep_mask <= '0;
      nz_count  <= '0;
    end else if (adv) begin
      a_valid   <= in_valid;
      a_mode    <= mask_mode;
      a_lifm    <= lifm_line;
      a_mt      <= mt_line;
      b_valid   <= a_valid;
      b_lifm    <= a_lifm;
      b_mt      <= a_mt;
      b_mask    <= a_mask;
      b_count   <= a_count;
      for (int i = 0; i < LINE_SIZE; i++) b_pos[i] <= a_pos[i];
      out_valid <= b_valid;
      lifm_comp <= c_lifm_n;
      mt_comp   <= c_mt_n;
      keep_mask <= b_mask;
      nz_count  <= b_count;
    end
  end

`ifdef ZVC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_lines <= '0;
      stat_zeros <= '0;
    end else if (out_valid && out_ready) begin
      stat_lines <= stat_lines + 32'd1;
      stat_zeros <= stat_zeros + (32'(LINE_SIZE) - 32'(nz_count));
    end
  end
`endif

endmodule

// File: tb/tb_zvc_compressor_pipe.sv
// tb/tb_zvc_compressor_pipe.sv - directed and random checks of zvc_compressor_pipe against a list-packing model.
module tb_zvc_compressor_pipe;

  localparam int WW  = 8;
  localparam int LS  = 32;
  localparam int DW  = 7;
  localparam int MR  = 3;
  localparam int CW  = $clog2(LS + 1);
  localparam int MTW = DW * MR;
  localparam int LW  = LS * WW;
  localparam int MW  = LS * MTW;

  logic          clk = 1'b0;
  logic          reset;
  logic          mask_mode;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] lifm_line;
  logic [MW-1:0] mt_line;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] lifm_comp;
  logic [MW-1:0] mt_comp;
  logic [LS-1:0] keep_mask;
  logic [CW-1:0] nz_count;
`ifdef ZVC_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_lines;
  logic [31:0]   stat_zeros;
  logic [31:0]   m_lines;
  logic [31:0]   m_zeros;
`endif

  always #5 clk = ~clk;

  zvc_compressor_pipe #(
    .WORD_WIDTH(WW), .LINE_SIZE(LS), .DIST_WIDTH(DW), .MAX_LIFM_RSIZ(MR)
  ) dut (
    .clk(clk), .reset(reset), .mask_mode(mask_mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .lifm_line(lifm_line), .mt_line(mt_line),
    .out_valid(out_valid), .out_ready(out_ready),
    .lifm_comp(lifm_comp), .mt_comp(mt_comp),
    .keep_mask(keep_mask), .nz_count(nz_count)
`ifdef ZVC_STATS_EN
    , .stat_clr(stat_clr), .stat_lines(stat_lines), .stat_zeros(stat_zeros)
`endif
  );

  typedef struct {
    logic [LW-1:0] lifm;
    logic [MW-1:0] mt;
    logic [LS-1:0] mask;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t pe [3];
  bit   pv [3];
  bit   live;
  bit   bp_en;
  int   cyc;
  int   compared;
  int   mismatched;

  // Kept words are appended to a growing output list in index order.
  function automatic exp_t ref_model(input logic [LW-1:0] l, input logic [MW-1:0] m, input logic md);
    exp_t r;
    int   n;
    bit   keep;
    n      = 0;
    r.lifm = '0;
    r.mt   = '0;
    r.mask = '0;
    for (int i = 0; i < LS; i++) begin
      keep = md ? (m[i*MTW +: MTW] != 0) : (l[i*WW +: WW] != 0);
      if (keep) begin
        r.mask[i]          = 1'b1;
        r.lifm[n*WW +: WW] = l[i*WW +: WW];
        r.mt[n*MTW +: MTW] = m[i*MTW +: MTW];
        n++;
      end
    end
    r.cnt = CW'(n);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(output bit acc);
    bit adv;
    acc = 0;
    adv = 1;
    if (bp_en) out_ready = (cyc % 3 == 0);
    #1;
    if (live) begin
      adv = !pv[2] || out_ready;
      chk("in_ready", in_ready, adv);
      chk("out_valid", out_valid, pv[2]);
      if (pv[2]) begin
        chk("lifm_comp", lifm_comp, pe[2].lifm);
        chk("mt_comp", mt_comp, pe[2].mt);
        chk("keep_mask", keep_mask, pe[2].mask);
        chk("nz_count", nz_count, pe[2].cnt);
      end
`ifdef ZVC_STATS_EN
      chk("stat_lines", stat_lines, m_lines);
      chk("stat_zeros", stat_zeros, m_zeros);
`endif
    end
    if (reset) begin
      for (int k = 0; k < 3; k++) pv[k] = 0;
      live = 1;
`ifdef ZVC_STATS_EN
      m_lines = 0;
      m_zeros = 0;
`endif
    end else if (live) begin
`ifdef ZVC_STATS_EN
      if (stat_clr) begin
        m_lines = 0;
        m_zeros = 0;
      end else if (pv[2] && out_ready) begin
        m_lines = m_lines + 1;
        m_zeros = m_zeros + (LS - int'(pe[2].cnt));
      end
`endif
      if (adv) begin
        pv[2] = pv[1]; pe[2] = pe[1];
        pv[1] = pv[0]; pe[1] = pe[0];
        pv[0] = in_valid;
        if (in_valid) pe[0] = ref_model(lifm_line, mt_line, mask_mode);
        acc = in_valid;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit g;
    in_valid = 0;
    repeat (n) tick(g);
  endtask

  task automatic send(input logic [LW-1:0] l, input logic [MW-1:0] m, input logic md);
    bit got;
    got       = 0;
    lifm_line = l;
    mt_line   = m;
    mask_mode = md;
    in_valid  = 1;
    for (int k = 0; k < 50 && !got; k++) tick(got);
    chk("accept", got, 1);
    in_valid = 0;
  endtask

  task automatic rand_line(output logic [LW-1:0] l, output logic [MW-1:0] m);
    for (int i = 0; i < LS; i++) begin
      l[i*WW +: WW]   = ($urandom % 3 == 0) ? '0 : WW'($urandom);
      m[i*MTW +: MTW] = ($urandom % 3 == 0) ? '0 : MTW'($urandom);
    end
  endtask

  initial begin
    logic [LW-1:0] l;
    logic [MW-1:0] m;
    logic [MW-1:0] mexp;
    bit            g;
    compared   = 0;
    mismatched = 0;
    live       = 0;
    bp_en      = 0;
    cyc        = 0;
    reset      = 1;
    in_valid   = 0;
    out_ready  = 1;
    mask_mode  = 0;
    lifm_line  = '0;
    mt_line    = '0;
`ifdef ZVC_STATS_EN
    stat_clr   = 0;
`endif
    tick(g);
    tick(g);
    reset = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lifm_comp", lifm_comp, 0);
    chk("rst_mt_comp", mt_comp, 0);
    chk("rst_keep_mask", keep_mask, 0);
    chk("rst_nz_count", nz_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Odd-indexed words carry their index, even words are zero.
    for (int i = 0; i < LS; i++) begin
      l[i*WW +: WW]   = (i % 2 == 1) ? WW'(i) : '0;
      m[i*MTW +: MTW] = MTW'(i * 5 + 3);
    end
    send(l, m, 0);
    idle(2);
    chk("s1_valid", out_valid, 1);
    chk("s1_count", nz_count, 16);
    chk("s1_mask", keep_mask, 32'hAAAA_AAAA);
    for (int j = 0; j < LS; j++)
      chk($sformatf("s1_slot%0d", j), lifm_comp[j*WW +: WW], (j < 16) ? 2 * j + 1 : 0);
    idle(1);

    l = '0;
    m = '0;
    for (int i = 0; i < LS; i++) l[i*WW +: WW] = 8'h55;
    m[0*MTW +: MTW]  = 21'd1;
    m[7*MTW +: MTW]  = 21'd22;
    m[31*MTW +: MTW] = 21'd94;
    send(l, m, 1);
    idle(2);
    mexp = '0;
    mexp[0 +: MTW]     = 21'd1;
    mexp[MTW +: MTW]   = 21'd22;
    mexp[2*MTW +: MTW] = 21'd94;
    chk("s2_valid", out_valid, 1);
    chk("s2_count", nz_count, 3);
    chk("s2_lifm", lifm_comp, 256'h555555);
    chk("s2_mt", mt_comp, mexp);
    idle(2);
`ifdef ZVC_STATS_EN
    chk("stat_lines_2", stat_lines, 2);
    chk("stat_zeros_45", stat_zeros, 45);
    stat_clr = 1;
    tick(g);
    stat_clr = 0;
    chk("stat_lines_clr", stat_lines, 0);
    chk("stat_zeros_clr", stat_zeros, 0);
`endif

    // All-zero line immediately followed by an all-kept line.
    send('0, '0, 0);
    for (int i = 0; i < LS; i++) begin
      l[i*WW +: WW]   = WW'(i + 1);
      m[i*MTW +: MTW] = MTW'($urandom);
    end
    send(l, m, 0);
    idle(1);
    chk("s3_zero_count", nz_count, 0);
    chk("s3_zero_lifm", lifm_comp, 0);
    idle(1);
    chk("s3_full_count", nz_count, LS);
    chk("s3_full_lifm", lifm_comp, l);
    chk("s3_full_mt", mt_comp, m);
    idle(2);

    bp_en = 1;
    for (int k = 0; k < 6; k++) begin
      rand_line(l, m);
      send(l, m, 1'($urandom));
    end
    idle(24);
    bp_en     = 0;
    out_ready = 1;

    // Fill all three stages under a stall, then reset.
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      rand_line(l, m);
      send(l, m, 0);
    end
    reset = 1;
    tick(g);
    reset     = 0;
    out_ready = 1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_keep", keep_mask, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    idle(5);
    rand_line(l, m);
    send(l, m, 0);
    idle(2);
    chk("post_rst_valid", out_valid, 1);
    idle(2);

    for (int k = 0; k < 300; k++) begin
      rand_line(l, m);
      lifm_line = ($urandom % 8 == 0) ? '0 : l;
      mt_line   = m;
      mask_mode = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = ($urandom % 4 != 0);
      tick(g);
    end
    in_valid  = 0;
    out_ready = 1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
